// File: rtl/result_serializer.sv
// Return-path serializer: collects encrypter results in strict round-robin order
// and streams each packet to the host as QSPI nibbles, least-significant first.
module result_serializer #(
    parameter int NUM_ENCRYPTERS  = 4,
    parameter int ENCRYPTER_WIDTH = 32,
    localparam int QSPI_COUNT     = ENCRYPTER_WIDTH / 4,
    localparam int IDX_W          = (NUM_ENCRYPTERS > 1) ? $clog2(NUM_ENCRYPTERS) : 1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_ENCRYPTERS*ENCRYPTER_WIDTH-1:0] encrypters_result,
    input  logic [NUM_ENCRYPTERS-1:0]                 encrypters_result_valid,
    output logic [NUM_ENCRYPTERS-1:0]                 encrypters_result_ack,
    output logic [3:0]                                qspi_data,
    output logic                                      qspi_sending,
    input  logic                                      qspi_ready,
    output logic                                      state_out,
    output logic [IDX_W-1:0]                          channel_index_out,
    output logic [15:0]                               packets_sent_out
);

    localparam int CNT_W = $clog2(QSPI_COUNT);

    typedef enum logic {
        IDLE    = 1'b0,
        SENDING = 1'b1
    } state_t;

    state_t                     state;
    logic [IDX_W-1:0]           idx;
    logic [IDX_W-1:0]           next_idx;
    logic [IDX_W-1:0]           sel_idx;
    logic [CNT_W-1:0]           cnt;
    logic [15:0]                sent;
    logic [ENCRYPTER_WIDTH-1:0] shift_reg;
    logic [ENCRYPTER_WIDTH-1:0] sel_data;
    logic [ENCRYPTER_WIDTH-1:0] chan [NUM_ENCRYPTERS];
    logic                       advance;
    logic                       last_accept;
    logic                       capture;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_ENCRYPTERS - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    function automatic logic [NUM_ENCRYPTERS-1:0] one_hot(input logic [IDX_W-1:0] i);
        logic [NUM_ENCRYPTERS-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    for (genvar i = 0; i < NUM_ENCRYPTERS; i++) begin : g_unpack
        assign chan[i] = encrypters_result[i*ENCRYPTER_WIDTH +: ENCRYPTER_WIDTH];
    end

    // On the final nibble the next channel is examined in the same cycle,
    // which is what allows back-to-back packets without a bubble.
    always_comb begin
        advance     = (state == SENDING) && qspi_ready;
        last_accept = advance && (cnt == CNT_W'(QSPI_COUNT - 1));
        next_idx    = wrap_inc(idx);
        sel_idx     = last_accept ? next_idx : idx;
        sel_data    = chan[sel_idx];
        capture     = ((state == IDLE) || last_accept) && encrypters_result_valid[sel_idx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                 <= IDLE;
            qspi_data             <= 4'h0;
            qspi_sending          <= 1'b0;
            encrypters_result_ack <= '0;
            idx                   <= '0;
            cnt                   <= '0;
            sent                  <= '0;
        end else begin
            encrypters_result_ack <= '0;
            case (state)
                IDLE: begin
                    if (capture) begin
                        encrypters_result_ack <= one_hot(sel_idx);
                        qspi_data             <= sel_data[3:0];
                        qspi_sending          <= 1'b1;
                        cnt                   <= '0;
                        state                 <= SENDING;
                    end
                end
                SENDING: begin
                    if (last_accept) begin
                        sent <= sent + 16'd1;
                        idx  <= next_idx;
                        if (capture) begin
                            encrypters_result_ack <= one_hot(sel_idx);
                            qspi_data             <= sel_data[3:0];
                            cnt                   <= '0;
                        end else begin
                            qspi_sending <= 1'b0;
                            qspi_data    <= 4'h0;
                            state        <= IDLE;
                        end
                    end else if (advance) begin
                        cnt       <= cnt + CNT_W'(1);
                        qspi_data <= shift_reg[7:4];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Packet payload needs no reset; its low nibble always mirrors qspi_data.
    always_ff @(posedge clk) begin
        if (capture) begin
            shift_reg <= sel_data;
        end else if (advance) begin
            shift_reg <= shift_reg >> 4;
        end
    end

    assign state_out         = (state == SENDING);
    assign channel_index_out = idx;
    assign packets_sent_out  = sent;

    ack_onehot: assert property (@(posedge clk) disable iff (!reset)
        $onehot0(encrypters_result_ack));

endmodule

// File: doc/result_serializer.md
Name: result_serializer

Overview:
- Return-path counterpart to the input parallelizer. Collects encrypted packets from the encrypter array in strict round-robin order (encrypter 0, 1, ..., NUM_ENCRYPTERS-1, 0, ...), the same order the parallelizer dispatches them.
- Streams each packet to the host as QSPI nibbles, least-significant nibble first, using a sending/ready handshake.
- Sits between the encrypter outputs and the external QSPI output pins.

Parameters:
NUM_ENCRYPTERS, 4, number of encrypter result channels
ENCRYPTER_WIDTH, 32, packet width in bits; must be a multiple of 4 and at least 8
QSPI_COUNT, ENCRYPTER_WIDTH/4, nibbles per packet (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
encrypters_result  input  NUM_ENCRYPTERS*ENCRYPTER_WIDTH  flattened result buses; channel i at [i*ENCRYPTER_WIDTH +: ENCRYPTER_WIDTH]
encrypters_result_valid  input  NUM_ENCRYPTERS  channel i holds a finished packet
encrypters_result_ack  output  NUM_ENCRYPTERS  one-cycle pulse: channel i packet captured
qspi_data  output  4  outgoing nibble
qspi_sending  output  1  high while a nibble is being presented
qspi_ready  input  1  host accepts the presented nibble on this edge
state_out  output  1  watcher: 0 = IDLE, 1 = SENDING
channel_index_out  output  clog2(NUM_ENCRYPTERS) max 1  watcher: next or current channel
packets_sent_out  output  16  watcher: completed packets, wraps at 2^16

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; qspi_data=0; qspi_sending=0; encrypters_result_ack=0.
  - channel index=0; nibble counter=0; packets_sent_out=0.
  - The shift register contents are don't-care.
- All outputs are registered.
- A nibble transfer occurs on any rising edge where qspi_sending=1 and qspi_ready=1.
- IDLE:
  - qspi_sending=0.
  - Only encrypters_result_valid[idx] is examined; valid on any other channel is ignored, which preserves ordering.
  - If valid[idx]=1 at an edge:
    - capture encrypters_result channel idx into the shift register;
    - ack[idx]<=1 for exactly one cycle;
    - qspi_data<=bits [3:0]; qspi_sending<=1; nibble counter<=0; go to SENDING.
  - First nibble appears 1 cycle after valid is sampled.
- SENDING:
  - qspi_ready=0: hold qspi_data, qspi_sending and the counter unchanged (stall, unbounded).
  - qspi_ready=1 and counter < QSPI_COUNT-1: counter+1; qspi_data<=next nibble (bits [4k+3:4k] for the new count k).
  - qspi_ready=1 and counter = QSPI_COUNT-1 (last nibble accepted):
    - packets_sent_out+1; idx advances, wrapping NUM_ENCRYPTERS-1 -> 0.
    - If valid[new idx]=1 on the same edge (back-to-back): capture it, pulse ack[new idx], present its nibble 0, counter<=0, keep qspi_sending=1, stay in SENDING. No bubble.
    - Otherwise: qspi_sending<=0, qspi_data<=0, go to IDLE.
- Ack rules:
  - Never more than one ack bit high at a time.
  - Ack is never asserted for a channel that is not valid.
  - The encrypter must drop valid within QSPI_COUNT cycles of ack. A channel is not re-sampled sooner than QSPI_COUNT cycles, since QSPI_COUNT >= 2.
- encrypters_result is sampled only on the capture edge; later changes do not affect the packet in flight.
- Reset mid-packet: the partial packet is discarded, no further nibbles are sent, idx returns to 0. The already-acked packet is lost; the host restarts its stream.
- qspi_ready is ignored in IDLE.

Test Plan:
- Single packet, ready held 1: ack[0] pulses 1 cycle; qspi_sending high 8 cycles; data F,E,D,C,B,A,9,8; then qspi_sending=0, packets_sent_out=1.
  - Stimulus: reset release; channel 0 result=0x89ABCDEF; valid[0] raised for 1 cycle.
- Ordering: valid[2] raised alone for 20 cycles -> no ack, qspi_sending stays 0. Then valid[0] and valid[1] raised -> channels 0, 1, 2 sent in that order.
- Stall: drop qspi_ready for 3 cycles while nibble index 4 (0xB) is presented -> qspi_data holds 0xB and counter frozen; stream then resumes with A,9,8.
- Back-to-back: channel 0=0x11111111 and channel 1=0x22222222 both valid -> 16 consecutive nibbles with qspi_sending continuously 1. ack[1] pulses on the edge accepting channel 0's last nibble.
- Wrap: 5 packets on channels 0,1,2,3,0 -> channel_index_out sequence 0,1,2,3,0,1; packets_sent_out=5.
- Reset mid-operation: pull reset low after 3 nibbles accepted -> qspi_sending, qspi_data, ack and counters are 0 immediately (before the next clock edge); after release, IDLE waits on channel 0.
